// File: rtl/dpe_pkg.sv
// Shared types and constants for the dot-product engine: run-state encoding
// and active-low seven-segment patterns ({a..g}, MSB = a).
package dpe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

endpackage

// File: rtl/seg7_decoder.sv
// Decimal digit to active-low seven-segment pattern. Values 10-15 have no
// decimal glyph and show the zero pattern.
module seg7_decoder
  import dpe_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/dot_product_engine.sv
// Saturating dot product of two small sample memories, paced by a tick strobe.
// Define DPE_SIGNED_EN for two's-complement arithmetic with symmetric saturation.
module dot_product_engine
  import dpe_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W:0]   n_samples,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              disp_sel,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ACC_W-1:0]  result,
  output logic [6:0]        seg_7
);

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W:0]     n_lat;
  logic [ADDR_W:0]     n_clip;
  logic [ACC_W-1:0]    acc;
  logic                ovf;

  logic [DATA_W-1:0]   mem_a [DEPTH] = '{default: DATA_W'(1)};
  logic [DATA_W-1:0]   mem_b [DEPTH] = '{default: DATA_W'(1)};
  logic [DATA_W-1:0]   a_rd;
  logic [DATA_W-1:0]   b_rd;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum_w;
  logic [ACC_W-1:0]    acc_next;
  logic                sat_hit;

  // Memories are only writable while idle, so a run always sees stable data.
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE) && ({1'b0, wr_addr} < DEPTH_W)) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
  end

  assign a_rd = mem_a[idx];
  assign b_rd = mem_b[idx];

`ifdef DPE_SIGNED_EN
  localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'((2 ** (ACC_W-1)) - 1);
  localparam logic signed [ACC_W:0] SMIN = -SMAX;

  assign prod  = $signed({{DATA_W{a_rd[DATA_W-1]}}, a_rd}) *
                 $signed({{DATA_W{b_rd[DATA_W-1]}}, b_rd});
  assign sum_w = {acc[ACC_W-1], acc} +
                 {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_comb begin
    acc_next = sum_w[ACC_W-1:0];
    sat_hit  = 1'b0;
    if ($signed(sum_w) > SMAX) begin
      acc_next = SMAX[ACC_W-1:0];
      sat_hit  = 1'b1;
    end else if ($signed(sum_w) < SMIN) begin
      acc_next = SMIN[ACC_W-1:0];
      sat_hit  = 1'b1;
    end
  end
`else
  assign prod  = {{DATA_W{1'b0}}, a_rd} * {{DATA_W{1'b0}}, b_rd};
  assign sum_w = {1'b0, acc} + {{(ACC_W+1-2*DATA_W){1'b0}}, prod};

  always_comb begin
    sat_hit  = sum_w[ACC_W];
    acc_next = sat_hit ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
  end
`endif

  always_comb begin
    n_clip = (n_samples > DEPTH_W) ? DEPTH_W : n_samples;
  end

  // Run protocol: start is taken only in IDLE; busy covers the N accumulating
  // ticks; done is a one-cycle pulse after the last product lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      n_lat <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            idx   <= '0;
            ovf   <= 1'b0;
            n_lat <= n_clip;
            state <= (n_clip == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (tick) begin
            acc <= acc_next;
            idx <= idx + 1'b1;
            if (sat_hit) ovf <= 1'b1;
            if (({1'b0, idx} + 1'b1) == n_lat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign overflow = ovf;
  assign result   = acc;

  seg7_decoder u_seg7 (
    .digit (disp_sel ? acc[3:0] : n_samples[3:0]),
    .seg   (seg_7)
  );

endmodule
